// File: rtl/fc3_bias_argmax.sv
// FC3 bias-add and running argmax: per batch, fetches bias from the ROM, adds it to the accepted accumulators
// and tracks the global max logit. Optional logit tap enabled by macro FC3_LOGIT_OUT_EN.
module fc3_bias_argmax #(
   parameter int N_LANE  = 16,
   parameter int N_BATCH = 2,
   parameter int W_ACC   = 40,
   parameter int W_BIAS  = 35,
   parameter int W_AA    = 4,
   parameter int W_IDX   = 8
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic                            start,
   input  logic                            acc_valid,
   output logic                            acc_ready,
   input  logic [N_LANE*W_ACC-1:0]         acc_data,
   output logic [W_AA-1:0]                 rom_aa,
   output logic                            rom_cena,
   input  logic [N_LANE*W_BIAS-1:0]        rom_qa,
   output logic                            busy,
   output logic                            done,
   output logic [W_IDX-1:0]                class_idx,
   output logic signed [W_ACC:0]           class_val,
`ifdef FC3_LOGIT_OUT_EN
   output logic                            logit_valid,
   output logic [W_AA-1:0]                 logit_batch,
   output logic [N_LANE*(W_ACC+1)-1:0]     logit_data,
`endif
   output logic [2:0]                      state_dbg
);

   localparam int W_S = W_ACC + 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_WAIT    = 3'd2,
      S_ACCEPT  = 3'd3,
      S_COMPARE = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t                state, state_nxt;
   logic [W_AA-1:0]       batch_cnt;
   logic [W_BIAS-1:0]     bias_reg [N_LANE];
   logic signed [W_S-1:0] sum_reg  [N_LANE];
   logic signed [W_S-1:0] sum_nxt  [N_LANE];
   logic signed [W_S-1:0] max_val;
   logic [W_IDX-1:0]      max_idx;
   logic signed [W_S-1:0] bat_max;
   logic [W_IDX-1:0]      bat_lane;
   logic [W_IDX-1:0]      bat_idx;
   logic                  take_new;
   logic                  last_batch;
   logic                  acc_fire;

   // Handshake: a batch transfers on a rising edge where acc_valid && acc_ready; acc_ready is raised only
   // in ACCEPT and does not depend on acc_valid; upstream holds acc_data stable while valid is high and unaccepted.
   assign acc_fire   = acc_valid && acc_ready;
   assign last_batch = (batch_cnt == W_AA'(N_BATCH - 1));
   assign busy       = (state != S_IDLE);
   assign state_dbg  = state;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      acc_ready = 1'b0;
      rom_cena  = 1'b1;
      rom_aa    = '0;
      done      = 1'b0;
      case (state)
         S_IDLE:    if (start) state_nxt = S_FETCH;
         S_FETCH: begin
            rom_cena  = 1'b0;
            rom_aa    = batch_cnt;
            state_nxt = S_WAIT;
         end
         S_WAIT:    state_nxt = S_ACCEPT;
         S_ACCEPT: begin
            acc_ready = 1'b1;
            if (acc_valid) state_nxt = S_COMPARE;
         end
         S_COMPARE: state_nxt = last_batch ? S_DONE : S_FETCH;
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Both operands sign-extended to W_ACC+1 so the sum cannot overflow.
   always_comb begin
      for (int i = 0; i < N_LANE; i++) begin
         sum_nxt[i] = $signed({acc_data[i*W_ACC + W_ACC - 1], acc_data[i*W_ACC +: W_ACC]})
                    + $signed({{(W_S - W_BIAS){bias_reg[i][W_BIAS-1]}}, bias_reg[i]});
      end
   end

   // Strict greater-than scan: the lowest lane keeps a tie.
   always_comb begin
      bat_max  = sum_reg[0];
      bat_lane = '0;
      for (int i = 1; i < N_LANE; i++) begin
         if (sum_reg[i] > bat_max) begin
            bat_max  = sum_reg[i];
            bat_lane = W_IDX'(i);
         end
      end
   end

   assign bat_idx  = W_IDX'(batch_cnt) * W_IDX'(N_LANE) + bat_lane;
   assign take_new = (bat_max > max_val);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         batch_cnt <= '0;
         max_val   <= '0;
         max_idx   <= '0;
         class_idx <= '0;
         class_val <= '0;
         for (int i = 0; i < N_LANE; i++) begin
            bias_reg[i] <= '0;
            sum_reg[i]  <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  batch_cnt <= '0;
                  max_val   <= {1'b1, {W_ACC{1'b0}}};
                  max_idx   <= '0;
               end
            end
            S_WAIT: begin
               for (int i = 0; i < N_LANE; i++) bias_reg[i] <= rom_qa[i*W_BIAS +: W_BIAS];
            end
            S_ACCEPT: begin
               if (acc_fire) begin
                  for (int i = 0; i < N_LANE; i++) sum_reg[i] <= sum_nxt[i];
               end
            end
            S_COMPARE: begin
               if (take_new) begin
                  max_val <= bat_max;
                  max_idx <= bat_idx;
               end
               // Result registers load here so they are already valid during the DONE cycle.
               if (last_batch) begin
                  class_idx <= take_new ? bat_idx : max_idx;
                  class_val <= take_new ? bat_max : max_val;
               end else begin
                  batch_cnt <= batch_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef FC3_LOGIT_OUT_EN
   assign logit_valid = (state == S_COMPARE);
   assign logit_batch = batch_cnt;
   always_comb begin
      for (int i = 0; i < N_LANE; i++) logit_data[i*W_S +: W_S] = sum_reg[i];
   end
`endif

endmodule

// File: tb/tb_fc3_bias_argmax.sv
// Directed bench for fc3_bias_argmax: small config, 1-cycle ROM model, hand-computed argmax results.
module tb_fc3_bias_argmax;

   localparam int N_LANE  = 4;
   localparam int N_BATCH = 2;
   localparam int W_ACC   = 16;
   localparam int W_BIAS  = 12;
   localparam int W_AA    = 4;
   localparam int W_IDX   = 8;
   localparam int W_S     = W_ACC + 1;
   localparam int W       = W_IDX + W_S;

   // clock / reset
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic                      start = 1'b0;
   logic                      acc_valid = 1'b0;
   logic                      acc_ready;
   logic [N_LANE*W_ACC-1:0]   acc_data = '0;
   logic [W_AA-1:0]           rom_aa;
   logic                      rom_cena;
   logic [N_LANE*W_BIAS-1:0]  rom_qa = '0;
   logic                      busy;
   logic                      done;
   logic [W_IDX-1:0]          class_idx;
   logic signed [W_S-1:0]     class_val;
   logic [2:0]                state_dbg;
`ifdef FC3_LOGIT_OUT_EN
   logic                      logit_valid;
   logic [W_AA-1:0]           logit_batch;
   logic [N_LANE*W_S-1:0]     logit_data;
   logic [W_AA-1:0]           lb_q[$];
   logic [N_LANE*W_S-1:0]     ld_q[$];
`endif

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   logic [W-1:0]      exp_q[$];
   logic [W_AA-1:0]   rd_q[$];
   logic [W_BIAS-1:0] bias_tab [2][4];

   fc3_bias_argmax #(
      .N_LANE(N_LANE), .N_BATCH(N_BATCH), .W_ACC(W_ACC),
      .W_BIAS(W_BIAS), .W_AA(W_AA), .W_IDX(W_IDX)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start),
      .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
      .rom_aa(rom_aa), .rom_cena(rom_cena), .rom_qa(rom_qa),
      .busy(busy), .done(done), .class_idx(class_idx), .class_val(class_val),
`ifdef FC3_LOGIT_OUT_EN
      .logit_valid(logit_valid), .logit_batch(logit_batch), .logit_data(logit_data),
`endif
      .state_dbg(state_dbg)
   );

   // bias ROM model, one-cycle read latency
   always @(posedge clk) begin
      if (!rom_cena) begin
         rom_qa <= {bias_tab[rom_aa[0]][3], bias_tab[rom_aa[0]][2],
                    bias_tab[rom_aa[0]][1], bias_tab[rom_aa[0]][0]};
         rd_q.push_back(rom_aa);
      end
   end

   always @(negedge clk) begin
      if (done) done_cnt++;
`ifdef FC3_LOGIT_OUT_EN
      if (logit_valid) begin
         lb_q.push_back(logit_batch);
         ld_q.push_back(logit_data);
      end
`endif
   end

   function automatic logic [N_LANE*W_ACC-1:0] pack_acc(input int a0, input int a1, input int a2, input int a3);
      logic [W_ACC-1:0] l0, l1, l2, l3;
      l0 = W_ACC'(a0); l1 = W_ACC'(a1); l2 = W_ACC'(a2); l3 = W_ACC'(a3);
      return {l3, l2, l1, l0};
   endfunction

   function automatic logic [N_LANE*W_S-1:0] pack_sum(input int a0, input int a1, input int a2, input int a3);
      logic [W_S-1:0] l0, l1, l2, l3;
      l0 = W_S'(a0); l1 = W_S'(a1); l2 = W_S'(a2); l3 = W_S'(a3);
      return {l3, l2, l1, l0};
   endfunction

   task automatic set_bias(input int b00, input int b01, input int b02, input int b03,
                           input int b10, input int b11, input int b12, input int b13);
      bias_tab[0][0] = W_BIAS'(b00); bias_tab[0][1] = W_BIAS'(b01);
      bias_tab[0][2] = W_BIAS'(b02); bias_tab[0][3] = W_BIAS'(b03);
      bias_tab[1][0] = W_BIAS'(b10); bias_tab[1][1] = W_BIAS'(b11);
      bias_tab[1][2] = W_BIAS'(b12); bias_tab[1][3] = W_BIAS'(b13);
   endtask

   // driver: one full image, acc_valid raised early so pre-ACCEPT cycles must ignore it
   task automatic run_image(input logic [N_LANE*W_ACC-1:0] a0, input logic [N_LANE*W_ACC-1:0] a1,
                            output logic [W_IDX-1:0] idx, output logic signed [W_S-1:0] val, output bit to);
      int n;
      to = 1'b0; idx = '0; val = '0;
      start = 1'b1; acc_valid = 1'b1; acc_data = a0;
      @(negedge clk);
      start = 1'b0;
      for (int b = 0; b < N_BATCH; b++) begin
         acc_data = (b == 0) ? a0 : a1;
         acc_valid = 1'b1;
         n = 0;
         while (!acc_ready && n < 20) begin @(negedge clk); n++; end
         if (!acc_ready) to = 1'b1;
         @(negedge clk);
         acc_valid = 1'b0;
      end
      n = 0;
      while (!done && n < 20) begin @(negedge clk); n++; end
      if (done) begin idx = class_idx; val = class_val; end
      else to = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset;
      total++; if (acc_ready !== 1'b0) begin bad++; $display("FAIL reset_acc_ready got=%b want=0", acc_ready); end
      total++; if (rom_cena !== 1'b1) begin bad++; $display("FAIL reset_rom_cena got=%b want=1", rom_cena); end
      total++; if (rom_aa !== 4'd0) begin bad++; $display("FAIL reset_rom_aa got=%0d want=0", rom_aa); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (class_idx !== 8'd0) begin bad++; $display("FAIL reset_class_idx got=%0d want=0", class_idx); end
      total++; if (class_val !== 17'd0) begin bad++; $display("FAIL reset_class_val got=%0d want=0", class_val); end
      @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic;
      logic [W_IDX-1:0] idx; logic signed [W_S-1:0] val; bit to; logic [W-1:0] e;
      rd_q.delete();
`ifdef FC3_LOGIT_OUT_EN
      lb_q.delete(); ld_q.delete();
`endif
      exp_q.push_back({8'd6, 17'd20});
      run_image(pack_acc(1, 2, 3, 4), pack_acc(0, 0, 20, 0), idx, val, to);
      e = exp_q.pop_front();
      total++; if (to) begin bad++; $display("FAIL basic_timeout got=1 want=0"); end
      total++; if (idx !== e[W-1 -: W_IDX]) begin bad++; $display("FAIL basic_idx got=%0d want=%0d", idx, e[W-1 -: W_IDX]); end
      total++; if (val !== e[W_S-1:0]) begin bad++; $display("FAIL basic_val got=%0d want=%0d", val, $signed(e[W_S-1:0])); end
      total++;
      if (rd_q.size() != 2) begin bad++; $display("FAIL basic_rom_reads got=%0d want=2", rd_q.size()); end
      else if (rd_q[0] !== 4'd0 || rd_q[1] !== 4'd1) begin
         bad++; $display("FAIL basic_rom_aa got=%0d,%0d want=0,1", rd_q[0], rd_q[1]);
      end
`ifdef FC3_LOGIT_OUT_EN
      total++;
      if (lb_q.size() != 2) begin bad++; $display("FAIL logit_pulses got=%0d want=2", lb_q.size()); end
      else begin
         total++; if (lb_q[0] !== 4'd0 || lb_q[1] !== 4'd1) begin
            bad++; $display("FAIL logit_batch got=%0d,%0d want=0,1", lb_q[0], lb_q[1]); end
         total++; if (ld_q[0] !== pack_sum(11, -3, 3, 7)) begin
            bad++; $display("FAIL logit_data0 got=%h want=%h", ld_q[0], pack_sum(11, -3, 3, 7)); end
         total++; if (ld_q[1] !== pack_sum(0, 0, 20, -100)) begin
            bad++; $display("FAIL logit_data1 got=%h want=%h", ld_q[1], pack_sum(0, 0, 20, -100)); end
      end
`endif
   endtask

   task automatic test_tie;
      logic [W_IDX-1:0] idx; logic signed [W_S-1:0] val; bit to; logic [W-1:0] e;
      exp_q.push_back({8'd0, 17'd15});
      run_image(pack_acc(5, 20, 15, 12), pack_acc(15, 15, 15, 115), idx, val, to);
      e = exp_q.pop_front();
      total++; if (to) begin bad++; $display("FAIL tie_timeout got=1 want=0"); end
      total++; if (idx !== e[W-1 -: W_IDX]) begin bad++; $display("FAIL tie_idx got=%0d want=%0d", idx, e[W-1 -: W_IDX]); end
      total++; if (val !== e[W_S-1:0]) begin bad++; $display("FAIL tie_val got=%0d want=%0d", val, $signed(e[W_S-1:0])); end
   endtask

   task automatic test_width;
      logic [W_IDX-1:0] idx; logic signed [W_S-1:0] val; bit to;
      logic signed [W_S-1:0] ev;
      run_image(pack_acc(32767, 0, 0, 0), pack_acc(0, 0, 0, 0), idx, val, to);
      ev = 17'sd32777;
      total++; if (to) begin bad++; $display("FAIL wpos_timeout got=1 want=0"); end
      total++; if (idx !== 8'd0) begin bad++; $display("FAIL wpos_idx got=%0d want=0", idx); end
      total++; if (val !== ev) begin bad++; $display("FAIL wpos_val got=%0d want=%0d", val, ev); end
      set_bias(-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048);
      run_image(pack_acc(-32768, -32768, -32768, -32768), pack_acc(-32768, -32768, -32768, -32768), idx, val, to);
      ev = -17'sd34816;
      total++; if (to) begin bad++; $display("FAIL wneg_timeout got=1 want=0"); end
      total++; if (idx !== 8'd0) begin bad++; $display("FAIL wneg_idx got=%0d want=0", idx); end
      total++; if (val !== ev) begin bad++; $display("FAIL wneg_val got=%0d want=%0d", val, ev); end
      set_bias(10, -5, 0, 3, 0, 0, 0, -100);
   endtask

   task automatic test_backpressure;
      int n; int nrd;
      rd_q.delete();
      start = 1'b1; acc_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!acc_ready && n < 20) begin @(negedge clk); n++; end
      total++; if (!acc_ready) begin bad++; $display("FAIL bp_ready_timeout got=0 want=1"); end
      nrd = rd_q.size();
      for (int k = 0; k < 10; k++) begin
         total++; if (acc_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_hold k=%0d got=%b want=1", k, acc_ready); end
         total++; if (rom_cena !== 1'b1) begin bad++; $display("FAIL bp_cena_hold k=%0d got=%b want=1", k, rom_cena); end
         start = (k == 4);
         @(negedge clk);
      end
      start = 1'b0;
      total++; if (rd_q.size() != nrd) begin bad++; $display("FAIL bp_no_refetch got=%0d want=%0d", rd_q.size(), nrd); end
      acc_data = pack_acc(1, 2, 3, 4); acc_valid = 1'b1;
      @(negedge clk);
      acc_data = pack_acc(0, 0, 20, 0);
      n = 0;
      while (!acc_ready && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      acc_valid = 1'b0;
      n = 0;
      while (!done && n < 20) begin @(negedge clk); n++; end
      total++; if (!done) begin bad++; $display("FAIL bp_done_timeout got=0 want=1"); end
      total++; if (class_idx !== 8'd6) begin bad++; $display("FAIL bp_idx got=%0d want=6", class_idx); end
      total++; if (class_val !== 17'sd20) begin bad++; $display("FAIL bp_val got=%0d want=20", class_val); end
      @(negedge clk);
      total++; if (rd_q.size() != 2) begin bad++; $display("FAIL bp_rom_reads got=%0d want=2", rd_q.size()); end
   endtask

   task automatic test_reset_mid;
      logic [W_IDX-1:0] idx; logic signed [W_S-1:0] val; bit to; int n; int dc;
      dc = done_cnt;
      start = 1'b1; acc_valid = 1'b1; acc_data = pack_acc(1, 2, 3, 4);
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!acc_ready && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      acc_valid = 1'b0;
      n = 0;
      while (!acc_ready && n < 20) begin @(negedge clk); n++; end
      total++; if (!acc_ready) begin bad++; $display("FAIL rm_batch1_timeout got=0 want=1"); end
      #2 rstn = 1'b0;
      #1;
      total++; if (acc_ready !== 1'b0) begin bad++; $display("FAIL rm_acc_ready got=%b want=0", acc_ready); end
      total++; if (rom_cena !== 1'b1) begin bad++; $display("FAIL rm_rom_cena got=%b want=1", rom_cena); end
      total++; if (rom_aa !== 4'd0) begin bad++; $display("FAIL rm_rom_aa got=%0d want=0", rom_aa); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b want=0", busy); end
      total++; if (class_idx !== 8'd0) begin bad++; $display("FAIL rm_class_idx got=%0d want=0", class_idx); end
      total++; if (class_val !== 17'd0) begin bad++; $display("FAIL rm_class_val got=%0d want=0", class_val); end
      @(negedge clk);
      rstn = 1'b1;
      repeat (6) @(negedge clk);
      total++; if (done_cnt != dc) begin bad++; $display("FAIL rm_no_done got=%0d want=%0d", done_cnt, dc); end
      run_image(pack_acc(1, 2, 3, 4), pack_acc(0, 0, 20, 0), idx, val, to);
      total++; if (to) begin bad++; $display("FAIL rm_rerun_timeout got=1 want=0"); end
      total++; if (idx !== 8'd6) begin bad++; $display("FAIL rm_rerun_idx got=%0d want=6", idx); end
      total++; if (val !== 17'sd20) begin bad++; $display("FAIL rm_rerun_val got=%0d want=20", val); end
   endtask

   initial begin
      set_bias(10, -5, 0, 3, 0, 0, 0, -100);
      repeat (2) @(negedge clk);
      test_reset();
      test_basic();
      test_tie();
      test_width();
      test_backpressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

endmodule

// File: doc/fc3_bias_argmax.md
Name: fc3_bias_argmax

Overview:
- Downstream consumer of the FC3 bias ROM. Receives FC3 accumulator vectors one output batch at a time over a valid/ready handshake.
- For each batch: fetches the matching bias vector from the ROM, adds bias to every lane, and keeps a running argmax across all batches.
- After the last batch, emits the winning class index and its biased logit as the network's final classification result.

Parameters:
- N_LANE, 16, outputs per batch; matches the ROM's per-word output count.
- N_BATCH, 2, output batches per image; ROM addresses used are 0..N_BATCH-1.
- W_ACC, 40, signed accumulator width per lane.
- W_BIAS, 35, signed bias width per lane. Must be ≤ W_ACC.
- W_AA, 4, ROM address width.
- W_IDX, 8, class index width. Must satisfy 2^W_IDX ≥ N_LANE*N_BATCH.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a new image. Ignored unless the FSM is in IDLE.
- acc_valid  in  1  acc_data holds a valid batch.
- acc_ready  out  1  block accepts acc_data this cycle.
- acc_data  in  N_LANE*W_ACC  packed signed sums; lane 0 in the LSBs.
- rom_aa  out  W_AA  bias ROM address.
- rom_cena  out  1  bias ROM read enable, active low.
- rom_qa  in  N_LANE*W_BIAS  bias word; lane 0 in the LSBs. Valid one cycle after the read.
- busy  out  1  high from start until done.
- done  out  1  one-cycle pulse; result is valid.
- class_idx  out  W_IDX  global index of the maximum logit (batch*N_LANE + lane).
- class_val  out  W_ACC+1  signed maximum biased logit.

Behaviour:
- Reset values: acc_ready=0, rom_cena=1, rom_aa=0, busy=0, done=0, class_idx=0, class_val=0. FSM state is IDLE, batch counter is 0.
- Reset is asynchronous and may occur mid-image. The image is abandoned and no done pulse is produced.
- FSM states:
  - IDLE: wait for start. On start: batch_cnt←0, max_val←most-negative (W_ACC+1)-bit value, max_idx←0, busy←1, go to FETCH.
  - FETCH: rom_cena=0 and rom_aa=batch_cnt for exactly one cycle; go to WAIT.
  - WAIT: one cycle; rom_qa becomes valid at the end of this cycle. Latch the bias vector into bias_reg; go to ACCEPT.
  - ACCEPT: acc_ready=1 and held high until acc_valid && acc_ready (the accept edge). On that edge, register sum[i] = sext(acc[i]) + sext(bias_reg[i]) at W_ACC+1 bits with no saturation (the extra bit prevents overflow); go to COMPARE.
  - COMPARE: one cycle. Compare the in-batch max against the running max. Within a batch, the lowest lane wins ties; across batches, a candidate replaces the running max only if strictly greater, so the earliest index wins ties. Update max_val and max_idx. If batch_cnt==N_BATCH-1, go to DONE; else batch_cnt++ and go to FETCH.
  - DONE: class_idx←max_idx, class_val←max_val, done=1 for one cycle, busy←0; go to IDLE.
- rom_cena is high in every state except FETCH, so the ROM output is stable outside reads.
- acc_ready is 0 in every state except ACCEPT. acc_data is sampled only on the accept edge.
- Per-batch latency: from the FETCH entry cycle to the accept cycle is ≥3 cycles (FETCH, WAIT, ACCEPT). COMPARE adds 1 cycle. DONE follows the last COMPARE by 1 cycle.
- class_idx and class_val hold their values until the next done. They are not cleared by start.
- start while busy is ignored. acc_valid outside ACCEPT is ignored and nothing is consumed.
- Most-negative edge case: if every logit equals the initial most-negative value, the result is class_idx=0.
- Upstream holds acc_data stable while acc_valid=1 && acc_ready=0 (standard valid/ready rule).

Optional Feature:
- Macro: FC3_LOGIT_OUT_EN.
- When defined, adds three output ports:
  - logit_valid (1): one-cycle pulse in COMPARE.
  - logit_batch (W_AA): current batch_cnt.
  - logit_data (N_LANE*(W_ACC+1)): the registered biased sums for that batch.
  - These feed the softmax/debug path. Reset values are 0.
- When undefined, these ports and their registers do not exist. All other behaviour and timing is identical.

Test Plan:
- Bench config N_LANE=4, N_BATCH=2, W_ACC=16, W_BIAS=12; ROM model with 1-cycle latency, bias[0]={10,-5,0,3}, bias[1]={0,0,0,-100}.
- Basic: acc batch0={1,2,3,4}, batch1={0,0,20,0} -> logits {11,-3,3,7},{0,0,20,-100}; done with class_idx=6, class_val=20. rom_aa=0 then 1, each with a single low cycle on rom_cena.
- Tie: batch0={5,20,15,12} -> {15,15,15,15}; batch1={15,15,15,115} -> {15,15,15,15}. Expect class_idx=0, class_val=15.
- Backpressure: keep acc_valid low for 10 cycles in ACCEPT. acc_ready stays high, no state advance, rom_cena stays high. Result matches the Basic case.
- Width extremes: acc=+32767 on lane 0 with bias +10 -> class_val=32777 (17-bit, no wrap). All lanes -32768 with bias -2048 -> class_val=-34816, class_idx=0.
- Reset mid-image: assert rstn=0 during batch1 ACCEPT. All outputs return to reset values and done never fires. A new start then produces the correct Basic result.
- With FC3_LOGIT_OUT_EN: two logit_valid pulses, with logit_batch=0 and 1, and logit_data matching the Basic logits.
